sync_fifo: RTL and testbench

Parametrised synchronous FIFO, successor to the UART byte FIFO, for the TX/RX datapaths and any other single-clock buffering in the design. It adds a single count register as the only occupancy state, and accepts simultaneous read and write when full. It also adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.

---
 rtl/fifo_pkg.sv | 32 +++
 rtl/fifo_mem.sv | 33 +++
 rtl/sync_fifo.sv | 162 ++++++++++++++++
 tb/tb_sync_fifo.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and parameter legality checks for sync_fifo.
//   addr_w(depth)  -> pointer width ($clog2(depth))
//   cnt_w(depth)   -> occupancy counter width (addr_w + 1, so DEPTH itself fits)
//   depth_ok / af_ok / ae_ok / dw_ok -> elaboration-time parameter checks
package fifo_pkg;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Power of two and at least 2, so the pointers are at least one bit wide.
    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit af_ok(input int af, input int depth);
        return (af >= 1) && (af <= depth);
    endfunction

    function automatic bit ae_ok(input int ae, input int depth);
        return (ae >= 0) && (ae <= depth - 1);
    endfunction

    function automatic bit dw_ok(input int dw);
        return dw >= 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x D_W storage array for sync_fifo.
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  asynchronous read data at raddr
// Contents are deliberately not reset or cleared; occupancy lives in the parent.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int D_W   = 8,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [addr_w(DEPTH)-1:0]   waddr,
    input  logic [D_W-1:0]             wdata,
    input  logic [addr_w(DEPTH)-1:0]   raddr,
    output logic [D_W-1:0]             rdata
);

    logic [D_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: parametrised single-clock FIFO with count-based flags, sticky
// overflow/underflow, synchronous flush and optional first-word-fall-through.
//   clk, rst         clock; asynchronous active-high reset
//   clr              synchronous flush (wins over wr_en/rd_en)
//   wr_en, data_in   write request and data
//   rd_en, data_out  read request and data
//   full, empty, almost_full, almost_empty, count   occupancy status
//   overflow, underflow                             sticky rejection flags
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int D_W       = 8,
    parameter int DEPTH     = 64,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [D_W-1:0]            data_in,
    output logic [D_W-1:0]            data_out,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int AW = addr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    if (!dw_ok(D_W)) begin : g_bad_dw
        $error("sync_fifo: D_W must be >= 1");
    end
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two >= 2");
    end
    if (!af_ok(AF_THRESH, DEPTH)) begin : g_bad_af
        $error("sync_fifo: AF_THRESH must be in 1..DEPTH");
    end
    if (!ae_ok(AE_THRESH, DEPTH)) begin : g_bad_ae
        $error("sync_fifo: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;
    logic           wr_acc, rd_acc;
    logic           full_w, empty_w;
    logic           mem_we;
    logic [D_W-1:0] head;

    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    always_comb begin
        // A full FIFO still takes a write when a read frees the slot this cycle.
        wr_acc   = wr_en & (~full_w | rd_en);
        rd_acc   = rd_en & ~empty_w;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        mem_we   = 1'b0;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            mem_we = wr_acc;
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            ovf_d = ovf_q | (wr_en & ~wr_acc);
            unf_d = unf_q | (rd_en & ~rd_acc);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    fifo_mem #(
        .D_W   (D_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (head)
    );

    if (FWFT != 0) begin : g_fwft
        // Head is shown directly; forced to zero while empty so stale memory never leaks.
        assign data_out = empty_w ? '0 : head;
    end else begin : g_std
        logic [D_W-1:0] data_out_q, data_out_d;

        always_comb begin
            data_out_d = data_out_q;
            if (clr) begin
                data_out_d = '0;
            end else if (rd_acc) begin
                data_out_d = head;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_out_q <= '0;
            end else begin
                data_out_q <= data_out_d;
            end
        end

        assign data_out = data_out_q;
    end

    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

    // Three configurations: 0 = DEPTH 8 registered, 1 = DEPTH 8 FWFT, 2 = DEPTH 4 registered.
    localparam int DEP [3] = '{8, 8, 4};
    localparam int FW  [3] = '{0, 1, 0};
    localparam int AFT [3] = '{4, 6, 3};
    localparam int AET [3] = '{2, 1, 1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] wr = '0, rd = '0, cl = '0;
    logic [2:0][7:0] din = '0;

    logic [7:0] dout0, dout1, dout2;
    logic [3:0] cnt0, cnt1;
    logic [2:0] cnt2;
    logic full0, full1, full2, empty0, empty1, empty2;
    logic af0, af1, af2, ae0, ae1, ae2;
    logic ovf0, ovf1, ovf2, unf0, unf1, unf2;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sync_fifo #(.D_W(8), .DEPTH(8), .FWFT(0), .AF_THRESH(4), .AE_THRESH(2)) u0 (
        .clk(clk), .rst(rst), .clr(cl[0]), .wr_en(wr[0]), .rd_en(rd[0]), .data_in(din[0]),
        .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .count(cnt0), .overflow(ovf0), .underflow(unf0));

    sync_fifo #(.D_W(8), .DEPTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(1)) u1 (
        .clk(clk), .rst(rst), .clr(cl[1]), .wr_en(wr[1]), .rd_en(rd[1]), .data_in(din[1]),
        .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .count(cnt1), .overflow(ovf1), .underflow(unf1));

    sync_fifo #(.D_W(8), .DEPTH(4), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)) u2 (
        .clk(clk), .rst(rst), .clr(cl[2]), .wr_en(wr[2]), .rd_en(rd[2]), .data_in(din[2]),
        .data_out(dout2), .full(full2), .empty(empty2), .almost_full(af2), .almost_empty(ae2),
        .count(cnt2), .overflow(ovf2), .underflow(unf2));

    // Reference model: contents as a list with the head at index 0.
    logic [7:0] mbuf [3][8];
    int         msz  [3];
    bit         movf [3];
    bit         munf [3];
    logic [7:0] mdout[3];

    function automatic logic [7:0] obs_dout(input int k);
        return (k == 0) ? dout0 : (k == 1) ? dout1 : dout2;
    endfunction

    function automatic logic [3:0] obs_cnt(input int k);
        return (k == 0) ? cnt0 : (k == 1) ? cnt1 : {1'b0, cnt2};
    endfunction

    // {full, empty, almost_full, almost_empty, overflow, underflow}
    function automatic logic [5:0] obs_flags(input int k);
        if (k == 0) return {full0, empty0, af0, ae0, ovf0, unf0};
        if (k == 1) return {full1, empty1, af1, ae1, ovf1, unf1};
        return {full2, empty2, af2, ae2, ovf2, unf2};
    endfunction

    function automatic logic [5:0] exp_flags(input int k);
        return {msz[k] == DEP[k], msz[k] == 0, msz[k] >= AFT[k], msz[k] <= AET[k], movf[k], munf[k]};
    endfunction

    function automatic logic [7:0] exp_dout(input int k);
        if (FW[k] != 0) return (msz[k] == 0) ? 8'h00 : mbuf[k][0];
        return mdout[k];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            msz[k] = 0; movf[k] = 1'b0; munf[k] = 1'b0; mdout[k] = 8'h00;
        end
    endtask

    task automatic model_step(input int k, input bit w, input bit r, input bit c, input logic [7:0] d);
        bit is_full, is_empty, wa, ra;
        if (c) begin
            msz[k] = 0; movf[k] = 1'b0; munf[k] = 1'b0; mdout[k] = 8'h00;
            return;
        end
        is_full  = (msz[k] == DEP[k]);
        is_empty = (msz[k] == 0);
        wa = w && (!is_full || r);
        ra = r && !is_empty;
        if (ra) begin
            if (FW[k] == 0) mdout[k] = mbuf[k][0];
            for (int i = 0; i < 7; i++) mbuf[k][i] = mbuf[k][i+1];
            msz[k]--;
        end
        if (wa) begin
            mbuf[k][msz[k]] = d;
            msz[k]++;
        end
        if (w && !wa) movf[k] = 1'b1;
        if (r && !ra) munf[k] = 1'b1;
    endtask

    task automatic cyc(input int k, input bit w, input bit r, input bit c, input logic [7:0] d);
        wr[k] = w; rd[k] = r; cl[k] = c; din[k] = d;
        @(posedge clk);
        model_step(k, w, r, c, d);
        #1;
        wr[k] = 1'b0; rd[k] = 1'b0; cl[k] = 1'b0;
    endtask

    task automatic test_reset();
        #3;  // still before the first clock edge
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (obs_cnt(k) !== 4'd0 || obs_flags(k) !== 6'b010100 || obs_dout(k) !== 8'h00) begin
                $display("FAIL reset[%0d]: cnt=%0d flags=%b dout=%h, want cnt=0 flags=010100 dout=00",
                         k, obs_cnt(k), obs_flags(k), obs_dout(k));
                tests_failed++;
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) cyc(0, 1'b1, 1'b0, 1'b0, 8'(i));
        tests_run++;
        if (cnt0 !== 4'd8 || full0 !== 1'b1 || af0 !== 1'b1 || empty0 !== 1'b0) begin
            $display("FAIL fill: cnt=%0d full=%b af=%b empty=%b, want 8 1 1 0", cnt0, full0, af0, empty0);
            tests_failed++;
        end
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1'b0, 1'b1, 1'b0, 8'h00);
            tests_run++;
            if (dout0 !== 8'(i)) begin
                $display("FAIL drain[%0d]: got %h want %h", i, dout0, 8'(i));
                tests_failed++;
            end
        end
        tests_run++;
        if (cnt0 !== 4'd0 || empty0 !== 1'b1) begin
            $display("FAIL drained: cnt=%0d empty=%b, want 0 1", cnt0, empty0);
            tests_failed++;
        end
    endtask

    task automatic test_over_under();
        for (int i = 0; i < 8; i++) cyc(0, 1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 127)));
        cyc(0, 1'b1, 1'b0, 1'b0, 8'hAA);
        tests_run++;
        if (ovf0 !== 1'b1 || cnt0 !== 4'd8 || unf0 !== 1'b0) begin
            $display("FAIL overflow: ovf=%b cnt=%0d unf=%b, want 1 8 0", ovf0, cnt0, unf0);
            tests_failed++;
        end
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1'b0, 1'b1, 1'b0, 8'h00);
            tests_run++;
            if (dout0 !== exp_dout(0) || dout0 === 8'hAA) begin
                $display("FAIL ovf_drain[%0d]: got %h want %h", i, dout0, exp_dout(0));
                tests_failed++;
            end
        end
        cyc(0, 1'b0, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if (unf0 !== 1'b1 || ovf0 !== 1'b1 || cnt0 !== 4'd0) begin
            $display("FAIL underflow: unf=%b ovf=%b cnt=%0d, want 1 1 0", unf0, ovf0, cnt0);
            tests_failed++;
        end
        cyc(0, 1'b0, 1'b0, 1'b1, 8'h00);
        tests_run++;
        if (ovf0 !== 1'b0 || unf0 !== 1'b0 || cnt0 !== 4'd0 || dout0 !== 8'h00) begin
            $display("FAIL clr: ovf=%b unf=%b cnt=%0d dout=%h, want 0 0 0 00", ovf0, unf0, cnt0, dout0);
            tests_failed++;
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) cyc(0, 1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 127)));
        cyc(0, 1'b1, 1'b1, 1'b0, 8'h55);
        tests_run++;
        if (cnt0 !== 4'd8 || ovf0 !== 1'b0 || dout0 !== exp_dout(0)) begin
            $display("FAIL full_rw: cnt=%0d ovf=%b dout=%h, want 8 0 %h", cnt0, ovf0, dout0, exp_dout(0));
            tests_failed++;
        end
        for (int i = 0; i < 8; i++) cyc(0, 1'b0, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if (dout0 !== 8'h55 || cnt0 !== 4'd0) begin
            $display("FAIL full_rw_last: dout=%h cnt=%0d, want 55 0", dout0, cnt0);
            tests_failed++;
        end
        cyc(0, 1'b1, 1'b1, 1'b0, 8'h11);
        tests_run++;
        if (cnt0 !== 4'd1 || unf0 !== 1'b1 || dout0 !== 8'h55) begin
            $display("FAIL empty_rw: cnt=%0d unf=%b dout=%h, want 1 1 55", cnt0, unf0, dout0);
            tests_failed++;
        end
        cyc(0, 1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_fwft();
        cyc(1, 1'b1, 1'b0, 1'b0, 8'h3C);
        tests_run++;
        if (dout1 !== 8'h3C || empty1 !== 1'b0) begin
            $display("FAIL fwft_fall: dout=%h empty=%b, want 3c 0", dout1, empty1);
            tests_failed++;
        end
        cyc(1, 1'b1, 1'b0, 1'b0, 8'hC3);
        tests_run++;
        if (dout1 !== 8'h3C || cnt1 !== 4'd2) begin
            $display("FAIL fwft_hold: dout=%h cnt=%0d, want 3c 2", dout1, cnt1);
            tests_failed++;
        end
        cyc(1, 1'b0, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if (dout1 !== 8'hC3) begin
            $display("FAIL fwft_adv: dout=%h want c3", dout1);
            tests_failed++;
        end
        cyc(1, 1'b0, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if (empty1 !== 1'b1 || dout1 !== 8'h00) begin
            $display("FAIL fwft_empty: empty=%b dout=%h, want 1 00", empty1, dout1);
            tests_failed++;
        end
    endtask

    task automatic test_wrap();
        cyc(2, 1'b0, 1'b0, 1'b1, 8'h00);
        cyc(2, 1'b1, 1'b0, 1'b0, 8'd1);
        cyc(2, 1'b1, 1'b0, 1'b0, 8'd2);
        for (int i = 0; i < 10; i++) begin
            cyc(2, 1'b1, 1'b1, 1'b0, 8'(3 + i));
            tests_run++;
            if (dout2 !== 8'(1 + i) || cnt2 !== 3'd2 || dout2 !== exp_dout(2)) begin
                $display("FAIL wrap[%0d]: dout=%h cnt=%0d, want %h 2", i, dout2, cnt2, 8'(1 + i));
                tests_failed++;
            end
        end
    endtask

    task automatic test_random();
        bit w, r, c;
        for (int k = 0; k < 3; k++) begin
            cyc(k, 1'b0, 1'b0, 1'b1, 8'h00);
            for (int i = 0; i < 400; i++) begin
                // Alternate write-heavy and read-heavy phases to reach full and empty.
                if (((i / 50) % 2) == 0) begin
                    w = ($urandom_range(0, 99) < 80);
                    r = ($urandom_range(0, 99) < 30);
                end else begin
                    w = ($urandom_range(0, 99) < 30);
                    r = ($urandom_range(0, 99) < 80);
                end
                c = ($urandom_range(0, 99) == 0);
                cyc(k, w, r, c, 8'($urandom));
                tests_run++;
                if (obs_cnt(k) !== 4'(msz[k]) || obs_flags(k) !== exp_flags(k) || obs_dout(k) !== exp_dout(k)) begin
                    $display("FAIL random[%0d/%0d]: cnt=%0d flags=%b dout=%h, want cnt=%0d flags=%b dout=%h",
                             k, i, obs_cnt(k), obs_flags(k), obs_dout(k), msz[k], exp_flags(k), exp_dout(k));
                    tests_failed++;
                end
            end
        end
    endtask

    task automatic test_async_reset();
        cyc(0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 6; i++) cyc(0, 1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
        cyc(0, 1'b0, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if (cnt0 !== 4'd5 || dout0 !== 8'h10) begin
            $display("FAIL pre_reset: cnt=%0d dout=%h, want 5 10", cnt0, dout0);
            tests_failed++;
        end
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if (cnt0 !== 4'd0 || empty0 !== 1'b1 || dout0 !== 8'h00) begin
            $display("FAIL async_reset: cnt=%0d empty=%b dout=%h, want 0 1 00", cnt0, empty0, dout0);
            tests_failed++;
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 1'b1, 1'b0, 1'b0, 8'h77);
        cyc(0, 1'b0, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if (dout0 !== 8'h77 || cnt0 !== 4'd0) begin
            $display("FAIL post_reset: dout=%h cnt=%0d, want 77 0", dout0, cnt0);
            tests_failed++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill_drain();
        test_over_under();
        test_simultaneous();
        test_fwft();
        test_wrap();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
